// File: rtl/spi_packet_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spi_packet_decoder
// Purpose  : Interprets the SPI slave byte stream as 4-byte command packets
//            framed by an active-low chip-select. Holds a small register bank,
//            commits checked writes and feeds response bytes back to the
//            slave transmit path for READ and STATUS commands.
// Ports    : sysClk, reset (sync, active-high)
//            cs (active-low, pre-synchronised), rx_byte/rx_valid (from slave)
//            tx_byte/tx_load (to slave), data_out (last committed write),
//            cmd_done / frame_err (1-cycle strobes), status (sticky flags)
// Options  : SPI_DECODER_CHECKSUM_EN - when defined, byte 3 of a WRITE must
//            equal (b0+b1+b2) mod 256 for the write to commit.
// Revision : 1.0 - initial release
// ============================================================================
module spi_packet_decoder #(
    parameter int NUM_REGS  = 4,
    parameter int PKT_BYTES = 4
) (
    input  logic       sysClk,
    input  logic       reset,
    input  logic       cs,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] tx_byte,
    output logic       tx_load,
    output logic [7:0] data_out,
    output logic       cmd_done,
    output logic       frame_err,
    output logic [7:0] status
);

    localparam int c_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] c_OP_NOP    = 2'b00;
    localparam logic [1:0] c_OP_WRITE  = 2'b01;
    localparam logic [1:0] c_OP_READ   = 2'b10;
    localparam logic [1:0] c_OP_STATUS = 2'b11;

    // Byte-slot states are encoded as the index of the next byte expected,
    // so the last data slot is derived from the packet length.
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_B1   = 3'd1;
    localparam logic [2:0] c_ST_B2   = 3'd2;
    localparam logic [2:0] c_ST_B3   = 3'(PKT_BYTES - 1);
    localparam logic [2:0] c_ST_DONE = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic            r_cs_q;
    logic [7:0]      r_cmd;
    logic [7:0]      r_b1;
    logic [7:0]      r_b2;
    logic [7:0]      r_regs [NUM_REGS];
    logic            r_overrun;
    logic            r_frame_err_s;
    logic            r_csum_err_s;
    logic            r_last_ok;
    logic [7:0]      r_tx_byte;
    logic            r_tx_load;
    logic [7:0]      r_data_out;
    logic            r_cmd_done;
    logic            r_frame_err;

    logic            w_rx_ok;
    logic [7:0]      w_status;
    logic [1:0]      w_op;
    logic [c_AW-1:0] w_addr;
    logic [7:0]      w_sum;
    logic            w_cmpl_ok;
    logic            w_csum_ok;
    logic            w_pass;
    logic            w_tx_load;
    logic [7:0]      w_tx_byte;
    logic            w_cap_b0;
    logic            w_cap_b1;
    logic            w_cap_b2;
    logic            w_complete;
    logic            w_abort;
    logic            w_overrun_set;

    // A byte arriving in the same cycle that cs first rises is still taken;
    // the abort is then seen on the following cycle.
    assign w_rx_ok   = rx_valid && (!cs || !r_cs_q);
    assign w_status  = {4'b0000, r_overrun, r_frame_err_s, r_csum_err_s, r_last_ok};
    assign w_op      = r_cmd[7:6];
    assign w_addr    = r_cmd[c_AW-1:0];
    assign w_sum     = r_cmd + r_b1 + r_b2;
    assign w_cmpl_ok = (r_b2 == ~r_b1);

`ifdef SPI_DECODER_CHECKSUM_EN
    assign w_csum_ok = (rx_byte == w_sum);
`else
    logic w_unused_sum;
    assign w_unused_sum = ^w_sum;
    assign w_csum_ok    = 1'b1;
`endif

    // Only WRITE carries checked payload; other commands always pass.
    assign w_pass = (w_op != c_OP_WRITE) || (w_cmpl_ok && w_csum_ok);

    // ---------------------------------------------------------------- state
    always_ff @(posedge sysClk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (rx_valid && !cs) w_next = c_ST_B1;
            c_ST_B1:   if (w_rx_ok) w_next = c_ST_B2;   else if (cs) w_next = c_ST_IDLE;
            c_ST_B2:   if (w_rx_ok) w_next = c_ST_B3;   else if (cs) w_next = c_ST_IDLE;
            c_ST_B3:   if (w_rx_ok) w_next = c_ST_DONE; else if (cs) w_next = c_ST_IDLE;
            c_ST_DONE: if (cs) w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_tx_load     = 1'b0;
        w_tx_byte     = r_tx_byte;
        w_cap_b0      = 1'b0;
        w_cap_b1      = 1'b0;
        w_cap_b2      = 1'b0;
        w_complete    = 1'b0;
        w_abort       = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (rx_valid && !cs) begin
                    w_cap_b0 = 1'b1;
                    // Command byte is not registered yet, so decode it live.
                    case (rx_byte[7:6])
                        c_OP_READ: begin
                            w_tx_load = 1'b1;
                            w_tx_byte = r_regs[rx_byte[c_AW-1:0]];
                        end
                        c_OP_STATUS: begin
                            w_tx_load = 1'b1;
                            w_tx_byte = w_status;
                        end
                        default: ;
                    endcase
                end
            end
            c_ST_B1: begin
                if (w_rx_ok) begin
                    w_cap_b1  = 1'b1;
                    w_tx_load = 1'b1;
                    case (w_op)
                        c_OP_READ:   w_tx_byte = ~r_regs[w_addr];
                        c_OP_STATUS: w_tx_byte = ~w_status;
                        default:     w_tx_byte = 8'h00;
                    endcase
                end else if (cs) begin
                    w_abort = 1'b1;
                end
            end
            c_ST_B2: begin
                if (w_rx_ok) begin
                    w_cap_b2  = 1'b1;
                    w_tx_load = 1'b1;
                    case (w_op)
                        c_OP_READ: w_tx_byte = w_status;
                        default:   w_tx_byte = 8'h00;
                    endcase
                end else if (cs) begin
                    w_abort = 1'b1;
                end
            end
            c_ST_B3: begin
                if (w_rx_ok)  w_complete = 1'b1;
                else if (cs)  w_abort    = 1'b1;
            end
            c_ST_DONE: begin
                if (w_rx_ok) w_overrun_set = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge sysClk) begin
        if (reset) begin
            r_cs_q        <= 1'b1;
            r_cmd         <= '0;
            r_b1          <= '0;
            r_b2          <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_overrun     <= 1'b0;
            r_frame_err_s <= 1'b0;
            r_csum_err_s  <= 1'b0;
            r_last_ok     <= 1'b0;
            r_tx_byte     <= '0;
            r_tx_load     <= 1'b0;
            r_data_out    <= '0;
            r_cmd_done    <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_cs_q      <= cs;
            r_tx_load   <= w_tx_load;
            r_cmd_done  <= w_complete && w_pass;
            r_frame_err <= w_abort;
            if (w_tx_load) r_tx_byte <= w_tx_byte;
            if (w_cap_b0)  r_cmd     <= rx_byte;
            if (w_cap_b1)  r_b1      <= rx_byte;
            if (w_cap_b2)  r_b2      <= rx_byte;
            if (w_abort)   r_frame_err_s <= 1'b1;
            if (w_overrun_set) r_overrun <= 1'b1;
            if (w_complete) begin
                if (w_pass) begin
                    r_last_ok <= 1'b1;
                    if (w_op == c_OP_WRITE) begin
                        r_regs[w_addr] <= r_b1;
                        r_data_out     <= r_b1;
                    end
                    if (w_op == c_OP_STATUS) begin
                        r_overrun     <= 1'b0;
                        r_frame_err_s <= 1'b0;
                        r_csum_err_s  <= 1'b0;
                    end
                end else begin
                    r_last_ok    <= 1'b0;
                    r_csum_err_s <= 1'b1;
                end
            end
        end
    end

    assign tx_byte   = r_tx_byte;
    assign tx_load   = r_tx_load;
    assign data_out  = r_data_out;
    assign cmd_done  = r_cmd_done;
    assign frame_err = r_frame_err;
    assign status    = w_status;

endmodule
`default_nettype wire
